// File: rtl/debug_char_pkg.sv
// Shared character codes (ASCII minus 32) and FSM states for the debugger display path.
`default_nettype none

package debug_char_pkg;

  localparam logic [6:0] CHAR_SPACE = 7'd0;
  localparam logic [6:0] CHAR_ZERO  = 7'd16;
  localparam logic [6:0] CHAR_X     = 7'd88;
  localparam logic [6:0] CHAR_LA    = 7'd65;
  localparam logic [6:0] CHAR_UA    = 7'd33;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    SEP   = 3'd4
  } hws_state_t;

endpackage

`default_nettype wire

// File: rtl/hex_nibble_char.sv
// Combinational decode of one hex nibble into a debugger character code.
`default_nettype none

module hex_nibble_char
  import debug_char_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  logic [6:0] alpha_base;

  always_comb begin
    alpha_base = UPPERCASE ? CHAR_UA : CHAR_LA;
    if (nibble < 4'd10) begin
      code = CHAR_ZERO + 7'(nibble);
    end else begin
      code = alpha_base + 7'(nibble) - 7'd10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hex_word_streamer.sv
// Serialises one WIDTH-bit word into hex characters, MSB nibble first, with
// optional "0x" prefix, leading-zero suppression and trailing separator.
`default_nettype none

module hex_word_streamer
  import debug_char_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter bit         UPPERCASE  = 1'b0,
  parameter bit         PREFIX_EN  = 1'b1,
  parameter bit         SKIP_ZEROS = 1'b0,
  parameter bit         SEP_EN     = 1'b1,
  parameter logic [6:0] SEP_CHAR   = 7'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int NDIG = WIDTH / 4;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef logic [IDXW-1:0] idx_t;

  hws_state_t       state;
  logic [WIDTH-1:0] word_q;
  idx_t             idx;

  idx_t             start_idx;
  idx_t             sel_idx;
  logic [WIDTH-1:0] sel_word;
  logic [3:0]       sel_nib;
  logic [6:0]       nib_code;

  // Start digit is resolved from the incoming word so suppression costs no cycles.
  always_comb begin
    start_idx = idx_t'(NDIG - 1);
    if (SKIP_ZEROS) begin
      start_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
        if (in_word[4*i +: 4] != 4'd0) begin
          start_idx = idx_t'(i);
        end
      end
    end
  end

  // Nibble feeding the next registered character: the capture-time word in IDLE,
  // the next-lower digit while streaming digits, else the current index.
  always_comb begin
    sel_word = word_q;
    sel_idx  = idx;
    case (state)
      IDLE: begin
        sel_word = in_word;
        sel_idx  = start_idx;
      end
      DIGIT:   sel_idx = idx - idx_t'(1);
      default: sel_idx = idx;
    endcase
    sel_nib = 4'(sel_word >> {sel_idx, 2'b00});
  end

  hex_nibble_char #(
    .UPPERCASE (UPPERCASE)
  ) u_nib (
    .nibble (sel_nib),
    .code   (nib_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_q    <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            word_q    <= in_word;
            idx       <= start_idx;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            if (PREFIX_EN) begin
              state    <= PFX0;
              out_char <= CHAR_ZERO;
              out_last <= 1'b0;
            end else begin
              state    <= DIGIT;
              out_char <= nib_code;
              out_last <= !SEP_EN && (start_idx == '0);
            end
          end
        end

        PFX0: begin
          if (out_ready) begin
            state    <= PFX1;
            out_char <= CHAR_X;
            out_last <= 1'b0;
          end
        end

        PFX1: begin
          if (out_ready) begin
            state    <= DIGIT;
            out_char <= nib_code;
            out_last <= !SEP_EN && (idx == '0);
          end
        end

        DIGIT: begin
          if (out_ready) begin
            if (idx == '0) begin
              if (SEP_EN) begin
                state    <= SEP;
                out_char <= SEP_CHAR;
                out_last <= 1'b1;
              end else begin
                state     <= IDLE;
                in_ready  <= 1'b1;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_char  <= '0;
                out_last  <= 1'b0;
              end
            end else begin
              idx      <= idx - idx_t'(1);
              out_char <= nib_code;
              out_last <= !SEP_EN && (idx == idx_t'(1));
            end
          end
        end

        SEP: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_char  <= '0;
            out_last  <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_char  <= '0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/hex_word_streamer.md
# hex_word_streamer

Parametrised hex-to-character serializer for the debugger display path. It accepts one WIDTH-bit word on a valid/ready handshake and emits its hexadecimal rendering one character per handshake, MSB nibble first. An optional "0x" prefix, leading-zero suppression and a trailing separator character are available. Characters use the debugger's 7-bit code, which is ASCII minus 32 (renderable characters only). The block feeds the character buffer and text renderer.

## Interface
- WIDTH, 32, input word width. Must be a multiple of 4 and at least 4. NDIG = WIDTH/4.
- UPPERCASE, 0, digits a–f encode as 33..38 when 1, and as 65..70 when 0.
- PREFIX_EN, 1, emit "0x" (codes 16, 88) before the digits.
- SKIP_ZEROS, 0, suppress leading zero digits. The least-significant digit is always emitted.
- SEP_EN, 1, emit SEP_CHAR after the last digit.
- SEP_CHAR, 7'd0, separator code. The default is space.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_word is offered
- in_ready  out  1  block will accept a word; high only in IDLE
- in_word  in  WIDTH  word to render
- out_valid  out  1  out_char is valid
- out_ready  in  1  consumer accepts out_char
- out_char  out  7  character code (ASCII−32)
- out_last  out  1  final character of the current word
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, PFX0, PFX1, DIGIT, SEP.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture in_word into the shift register.
  - Compute the start digit index. It is NDIG−1, or with SKIP_ZEROS the index of the highest nonzero nibble (0 if the word is zero).
  - Next state is PFX0 if PREFIX_EN, else DIGIT.
- **PFX0** emits 16 ('0'). **PFX1** emits 88 ('x'). Then go to DIGIT.
- **DIGIT**
  - Emits the nibble at the current index, decoded as: 0–9 → 16..25; a–f → 65..70 or 33..38.
  - Index decrements on each accepted character.
  - After index 0 is accepted: go to SEP if SEP_EN, else IDLE.
- **SEP** emits SEP_CHAR, then returns to IDLE.
- A state advances only on out_valid&&out_ready.
- out_last=1 on the final emitted character: SEP if SEP_EN, else digit index 0.
- Backpressure: while out_valid&&!out_ready, out_char, out_last and all state hold stable.
- in_word changes while busy have no effect.
- Reset value of every output:
  - in_ready=1
  - out_valid=0
  - out_char=0
  - out_last=0
  - busy=0
- Reset mid-word returns immediately to IDLE. The remaining characters are discarded and no partial out_last is issued.

## Timing
- Word accepted at edge N: the first character is valid in cycle N+1. out_valid, out_char and out_last derive only from registered state, with no in→out combinational path.
- With out_ready held high, one character is emitted per cycle.
- A word costs (PREFIX_EN?2:0) + emitted digits + (SEP_EN?1:0) cycles, plus 1 IDLE cycle before the next acceptance.
- in_ready rises in the cycle after the out_last handshake. There is no overlap between words.
- Skipping leading zeros costs zero cycles. The start index is resolved at capture time.
- The digit index counter is max(1,$clog2(NDIG)) bits wide and never wraps below 0.

## Structure
- Package debug_char_pkg holds:
  - constants CHAR_SPACE=0, CHAR_ZERO=16, CHAR_X=88, CHAR_LA=65, CHAR_UA=33;
  - the FSM state enum.
- Sub-module hex_nibble_char handles the combinational nibble→code decode. It takes an UPPERCASE parameter and is instantiated once on the selected nibble.
- The leading-zero priority encoder stays inline.

## Test plan
- **Base case.** WIDTH=16, defaults, in_word=16'h0A3F, out_ready=1.
  - Required sequence: 16, 88, 16, 65, 19, 70, 0.
  - out_last is asserted only on the final 0.
  - in_ready returns 1 cycle later.
- **Uppercase, no prefix or separator.** UPPERCASE=1, PREFIX_EN=0, SEP_EN=0, in_word=16'hBEEF.
  - Required sequence: 34, 37, 37, 38.
  - out_last is on 38.
- **Leading-zero suppression.** SKIP_ZEROS=1, PREFIX_EN=0, SEP_EN=0.
  - in_word=16'h0000 → single 16 with out_last.
  - in_word=16'h00C4 → 67, 20.
- **Backpressure.** out_ready toggles 1,0,0,1… during 16'h1234.
  - Characters hold stable across the stalls.
  - Output is exactly 16, 88, 17, 18, 19, 20, 0 with no duplicates or drops.
  - in_valid pulses while busy are ignored.
- **Reset mid-word.** Assert rst_n=0 after the second character of 32'hDEADBEEF.
  - Outputs take their reset values asynchronously.
  - After release the block is in IDLE with in_ready=1.
  - A new word 32'h1 then renders fully and correctly.
